// File: rtl/flex_fifo.sv
// Parameterised synchronous FIFO with level-derived status flags, sticky error flags
// and a selectable registered-read or first-word-fall-through output stage.
module flex_fifo #(
    parameter int DATA_WIDTH             = 8,
    parameter int INDEX_WIDTH            = 5,
    parameter int ALMOST_FULL_THRESHOLD  = 28,
    parameter int ALMOST_EMPTY_THRESHOLD = 4,
    parameter int FWFT                   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [INDEX_WIDTH:0]  level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** INDEX_WIDTH;
    localparam logic [INDEX_WIDTH:0]   DEPTH_LVL = (INDEX_WIDTH + 1)'(DEPTH);
    localparam logic [INDEX_WIDTH:0]   AF_LVL    = (INDEX_WIDTH + 1)'(ALMOST_FULL_THRESHOLD);
    localparam logic [INDEX_WIDTH:0]   AE_LVL    = (INDEX_WIDTH + 1)'(ALMOST_EMPTY_THRESHOLD);
    localparam logic [INDEX_WIDTH:0]   LVL_ONE   = 1;
    localparam logic [INDEX_WIDTH-1:0] PTR_ONE   = 1;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [INDEX_WIDTH-1:0] wr_ptr;
    logic [INDEX_WIDTH-1:0] rd_ptr;
    logic                   wr_acc;
    logic                   rd_acc;

    // Acceptance looks only at the registered flags, so a pop never frees room
    // for a same-cycle push and a push never feeds a same-cycle pop.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    assign full         = (level == DEPTH_LVL);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            // A new error in the clearing cycle keeps the flag set.
            overflow  <= (wr_en && full)  || (overflow  && !clr_err);
            underflow <= (rd_en && empty) || (underflow && !clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown combinationally; zero while empty so reset reads 0.
            assign rd_data  = empty ? '0 : mem[rd_ptr];
            assign rd_valid = !empty;
        end else begin : g_registered
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) rd_data <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_flex_fifo.sv
// Bench for flex_fifo: queue-model scoreboard on a registered-read instance,
// a vector table for the basic write/read run, and short FWFT sequences.
module tb_flex_fifo;

    localparam int DW    = 8;
    localparam int IW    = 5;
    localparam int DEPTH = 32;
    localparam int AF    = 28;
    localparam int AE    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en, rd_en, clr_err;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [IW:0]   level;

    logic          f_wr_en, f_rd_en, f_clr_err;
    logic [DW-1:0] f_wr_data, f_rd_data;
    logic          f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [IW:0]   f_level;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    typedef struct {
        logic          w;
        logic [DW-1:0] d;
        logic          r;
        logic [IW:0]   lvl;
        logic          v;
        logic [DW-1:0] q;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    flex_fifo #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .ALMOST_FULL_THRESHOLD(AF),
                .ALMOST_EMPTY_THRESHOLD(AE), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    flex_fifo #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .ALMOST_FULL_THRESHOLD(AF),
                .ALMOST_EMPTY_THRESHOLD(AE), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .clr_err(f_clr_err), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .level(f_level), .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        int lvl;
        lvl = model_q.size();
        chk("level",        32'(level),        32'(lvl));
        chk("empty",        32'(empty),        32'(lvl == 0));
        chk("full",         32'(full),         32'(lvl == DEPTH));
        chk("almost_full",  32'(almost_full),  32'(lvl >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(lvl <= AE));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
    endtask

    // One clock of stimulus on the registered-read instance; model updated from pre-edge state.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        int            lvl;
        logic          wacc, racc;
        logic [DW-1:0] e;
        lvl   = model_q.size();
        wacc  = w && (lvl != DEPTH);
        racc  = r && (lvl != 0);
        m_ovf = (w && lvl == DEPTH) || (m_ovf && !c);
        m_udf = (r && lvl == 0)     || (m_udf && !c);
        if (racc) exp_q.push_back(model_q.pop_front());
        if (wacc) model_q.push_back(d);
        wr_en = w; wr_data = d; rd_en = r; clr_err = c;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        chk("rd_valid", 32'(rd_valid), 32'(racc));
        if (racc) begin
            e = exp_q.pop_front();
            chk("rd_data", 32'(rd_data), 32'(e));
        end
        check_status();
    endtask

    task automatic drain();
        while (model_q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic f_cycle(input logic w, input logic [DW-1:0] d, input logic r);
        f_wr_en = w; f_wr_data = d; f_rd_en = r;
        @(posedge clk); #1;
        f_wr_en = 1'b0; f_rd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wr_en = 0; rd_en = 0; clr_err = 0; wr_data = '0;
        f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_wr_data = '0;
        vecs = '{
            '{1'b1, 8'h01, 1'b0, 6'd1, 1'b0, 8'h00},
            '{1'b1, 8'h02, 1'b0, 6'd2, 1'b0, 8'h00},
            '{1'b1, 8'h03, 1'b0, 6'd3, 1'b0, 8'h00},
            '{1'b1, 8'h04, 1'b0, 6'd4, 1'b0, 8'h00},
            '{1'b1, 8'h05, 1'b0, 6'd5, 1'b0, 8'h00},
            '{1'b0, 8'h00, 1'b1, 6'd4, 1'b1, 8'h01},
            '{1'b0, 8'h00, 1'b1, 6'd3, 1'b1, 8'h02},
            '{1'b0, 8'h00, 1'b1, 6'd2, 1'b1, 8'h03},
            '{1'b0, 8'h00, 1'b1, 6'd1, 1'b1, 8'h04},
            '{1'b0, 8'h00, 1'b1, 6'd0, 1'b1, 8'h05},
            '{1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 8'h05}
        };

        // Reset
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #12;
        check_status();
        chk("rst_rd_valid",   32'(rd_valid),   32'(0));
        chk("rst_rd_data",    32'(rd_data),    32'(0));
        chk("rst_f_rd_valid", 32'(f_rd_valid), 32'(0));
        chk("rst_f_empty",    32'(f_empty),    32'(1));
        @(negedge clk) rst_n = 1'b1;

        // Basic write 1..5 / read 5 from the vector table
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].w, vecs[i].d, vecs[i].r, 1'b0);
            chk("vec_level",    32'(level),    32'(vecs[i].lvl));
            chk("vec_rd_valid", 32'(rd_valid), 32'(vecs[i].v));
            chk("vec_rd_data",  32'(rd_data),  32'(vecs[i].q));
        end
        chk("vec_empty_end", 32'(empty), 32'(1));

        // Fill to full, overflow, clear, drain
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        chk("fill_full",  32'(full),  32'(1));
        chk("fill_level", 32'(level), 32'(DEPTH));
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("fill_overflow", 32'(overflow), 32'(1));
        cycle(1'b1, 8'hEF, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("fill_clr", 32'(overflow), 32'(0));
        drain();

        // Underflow, concurrent write into empty
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_flag",  32'(underflow), 32'(1));
        chk("udf_level", 32'(level),     32'(0));
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("udf_wr_level", 32'(level), 32'(1));
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        drain();

        // Simultaneous read/write at level 10 across pointer wraps
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, 8'(10 + i), 1'b1, 1'b0);
        chk("simul_level", 32'(level), 32'(10));
        drain();

        // Random mixed traffic, write-biased then read-biased
        for (int i = 0; i < 300; i++) begin
            logic w, r, c;
            w = (i < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            cycle(w, 8'($urandom_range(0, 255)), r, c);
        end
        drain();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // FWFT instance
        chk("fwft_idle_valid", 32'(f_rd_valid), 32'(0));
        f_cycle(1'b1, 8'h5A, 1'b0);
        chk("fwft_first_valid", 32'(f_rd_valid), 32'(1));
        chk("fwft_first_data",  32'(f_rd_data),  32'(8'h5A));
        f_cycle(1'b0, 8'h00, 1'b1);
        chk("fwft_pop_empty", 32'(f_empty),    32'(1));
        chk("fwft_pop_valid", 32'(f_rd_valid), 32'(0));
        f_cycle(1'b1, 8'h11, 1'b0);
        f_cycle(1'b1, 8'h22, 1'b0);
        chk("fwft_head_hold", 32'(f_rd_data), 32'(8'h11));
        f_cycle(1'b0, 8'h00, 1'b1);
        chk("fwft_next_data", 32'(f_rd_data), 32'(8'h22));
        chk("fwft_level",     32'(f_level),   32'(1));

        // Reset mid-operation at level 17
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        chk("pre_rst_level", 32'(level), 32'(17));
        rst_n = 1'b0;
        #2;
        model_q.delete(); exp_q.delete();
        m_ovf = 1'b0; m_udf = 1'b0;
        chk("rst_mid_level",    32'(level),     32'(0));
        chk("rst_mid_empty",    32'(empty),     32'(1));
        chk("rst_mid_udf",      32'(underflow), 32'(0));
        chk("rst_mid_rd_valid", 32'(rd_valid),  32'(0));
        chk("rst_mid_f_level",  32'(f_level),   32'(0));
        @(negedge clk) rst_n = 1'b1;
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_data", 32'(rd_data), 32'(8'h33));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
